// File: rtl/cipher_pkg.sv
// Shared types for the block-cipher mode controller: mode codes, FSM states
// and the decode that folds the reserved mode onto ECB.
package cipher_pkg;

  typedef enum logic [1:0] {
    MODE_ECB  = 2'b00,
    MODE_CBC  = 2'b01,
    MODE_CTR  = 2'b10,
    MODE_RSVD = 2'b11
  } cipher_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    HOLD = 2'b10
  } cipher_state_e;

  // The reserved encoding runs as plain ECB.
  function automatic cipher_mode_e eff_mode(input logic [1:0] mode);
    return (mode == MODE_RSVD) ? MODE_ECB : cipher_mode_e'(mode);
  endfunction

endpackage

// File: rtl/cipher_mode_ctrl_if.sv
// Host stream (valid/ready both ways) plus pulse-valid cipher core port.
// The slave modport is the controller's view; master is the integration side.
interface cipher_mode_ctrl_if #(
  parameter int BLOCK_W = 64,
  parameter int KEY_W   = 64
) ();

  logic               start_i;
  logic [1:0]         mode_i;
  logic               dec_i;
  logic [KEY_W-1:0]   key_i;
  logic [BLOCK_W-1:0] iv_i;
  logic [BLOCK_W-1:0] data_i;
  logic               valid_i;
  logic               ready_o;
  logic [BLOCK_W-1:0] data_o;
  logic               valid_o;
  logic               ready_i;
  logic               core_mode_o;
  logic [KEY_W-1:0]   core_key_o;
  logic [BLOCK_W-1:0] core_data_o;
  logic               core_valid_o;
  logic [BLOCK_W-1:0] core_data_i;
  logic               core_valid_i;

  modport slave (
    input  start_i, mode_i, dec_i, key_i, iv_i, data_i, valid_i, ready_i,
    input  core_data_i, core_valid_i,
    output ready_o, data_o, valid_o,
    output core_mode_o, core_key_o, core_data_o, core_valid_o
  );

  modport master (
    output start_i, mode_i, dec_i, key_i, iv_i, data_i, valid_i, ready_i,
    output core_data_i, core_valid_i,
    input  ready_o, data_o, valid_o,
    input  core_mode_o, core_key_o, core_data_o, core_valid_o
  );

endinterface

// File: rtl/cipher_ctr_inc.sv
// Counter-block incrementer: low CTR_W bits wrap modulo 2^CTR_W, the nonce
// bits above them pass through untouched.
module cipher_ctr_inc #(
  parameter int BLOCK_W = 64,
  parameter int CTR_W   = 32
) (
  input  logic [BLOCK_W-1:0] cur,
  output logic [BLOCK_W-1:0] nxt
);

  if (CTR_W >= BLOCK_W) begin : g_full
    assign nxt = cur + BLOCK_W'(1);
  end else begin : g_split
    assign nxt = {cur[BLOCK_W-1:CTR_W], cur[CTR_W-1:0] + CTR_W'(1)};
  end

endmodule

// File: rtl/cipher_mode_ctrl.sv
// ECB/CBC/CTR mode controller around an external pulse-valid cipher core.
// One block in flight: accept -> core request -> hold result until taken.
module cipher_mode_ctrl
  import cipher_pkg::*;
#(
  parameter int BLOCK_W = 64,
  parameter int KEY_W   = 64,
  parameter int CTR_W   = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  cipher_mode_ctrl_if.slave bus
);

  cipher_state_e      state_q, state_d;
  logic               ready_q, valid_q, core_valid_q;
  logic [BLOCK_W-1:0] data_out_q, core_data_q, data_q, chain_q;
  cipher_mode_e       mode_q;
  logic               dec_q;
  logic [KEY_W-1:0]   key_q;

  logic               accept, core_done;
  cipher_mode_e       sel_mode;
  logic               sel_dec;
  logic [BLOCK_W-1:0] sel_chain, core_in, result, chain_next, chain_inc;

  // ready_q is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept    = bus.valid_i & ready_q;
  // A core pulse coinciding with our own request pulse is stale, not ours.
  assign core_done = (state_q == BUSY) & bus.core_valid_i & ~core_valid_q;

  cipher_ctr_inc #(.BLOCK_W(BLOCK_W), .CTR_W(CTR_W)) u_ctr_inc (
    .cur (chain_q),
    .nxt (chain_inc)
  );

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    sel_mode  = mode_q;
    sel_dec   = dec_q;
    sel_chain = chain_q;
    if (bus.start_i) begin
      sel_mode  = eff_mode(bus.mode_i);
      sel_dec   = bus.dec_i;
      sel_chain = bus.iv_i;
    end
    core_in = bus.data_i;
    case (sel_mode)
      MODE_CBC: if (!sel_dec) core_in = bus.data_i ^ sel_chain;
      MODE_CTR: core_in = sel_chain;
      default:  ;
    endcase
  end

  always_comb begin
    result     = bus.core_data_i;
    chain_next = chain_q;
    case (mode_q)
      MODE_CBC: begin
        if (dec_q) begin
          result     = bus.core_data_i ^ chain_q;
          chain_next = data_q;
        end else begin
          chain_next = bus.core_data_i;
        end
      end
      MODE_CTR: begin
        result     = bus.core_data_i ^ data_q;
        chain_next = chain_inc;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = BUSY;
      BUSY:    if (core_done)   state_d = HOLD;
      HOLD:    if (bus.ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ready_q      <= 1'b0;
      valid_q      <= 1'b0;
      core_valid_q <= 1'b0;
      data_out_q   <= '0;
      core_data_q  <= '0;
      data_q       <= '0;
      chain_q      <= '0;
      mode_q       <= MODE_ECB;
      dec_q        <= 1'b0;
      key_q        <= '0;
    end else begin
      ready_q      <= (state_d == IDLE);
      core_valid_q <= accept;
      if (accept) begin
        data_q      <= bus.data_i;
        core_data_q <= core_in;
        chain_q     <= sel_chain;
        if (bus.start_i) begin
          mode_q <= sel_mode;
          dec_q  <= sel_dec;
          key_q  <= bus.key_i;
        end
      end
      if (core_done) begin
        data_out_q <= result;
        valid_q    <= 1'b1;
        chain_q    <= chain_next;
      end else if ((state_q == HOLD) && bus.ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.ready_o      = ready_q;
  assign bus.valid_o      = valid_q;
  assign bus.data_o       = data_out_q;
  assign bus.core_valid_o = core_valid_q;
  assign bus.core_data_o  = core_data_q;
  assign bus.core_key_o   = key_q;
  assign bus.core_mode_o  = (mode_q == MODE_CTR) ? 1'b0 : dec_q;

endmodule

// File: tb/tb_cipher_mode_ctrl.sv
// Scoreboard bench for cipher_mode_ctrl with an XOR stub core (latency 3) that
// also answers the single DES known-answer vector in both directions.
module tb_cipher_mode_ctrl;
  import cipher_pkg::*;

  localparam int          BW     = 64;
  localparam int          KW     = 64;
  localparam int          LAT    = 3;
  localparam logic [63:0] K_STUB = 64'h0F0F0F0F0F0F0F0F;
  localparam logic [63:0] DES_K  = 64'h133457799BBCDFF1;
  localparam logic [63:0] DES_P  = 64'h0123456789ABCDEF;
  localparam logic [63:0] DES_C  = 64'h85E813540F0AB405;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk_i = ~clk_i;

  cipher_mode_ctrl_if #(.BLOCK_W(BW), .KEY_W(KW)) bus ();

  cipher_mode_ctrl #(.BLOCK_W(BW), .KEY_W(KW), .CTR_W(32)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] core_in_log[$];
  int          n_tests    = 0;
  int          n_fail     = 0;
  int          n_core     = 0;
  int          pulses_exp = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] core_model(input logic [63:0] din, input logic [63:0] key,
                                             input logic dec);
    if (key == DES_K && !dec && din == DES_P) return DES_C;
    if (key == DES_K &&  dec && din == DES_C) return DES_P;
    return din ^ key;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic check_zero_outs(input string pfx);
    check({pfx, "_ready_o"},      64'(bus.ready_o),      64'd0);
    check({pfx, "_valid_o"},      64'(bus.valid_o),      64'd0);
    check({pfx, "_data_o"},       bus.data_o,            64'd0);
    check({pfx, "_core_valid_o"}, 64'(bus.core_valid_o), 64'd0);
    check({pfx, "_core_data_o"},  bus.core_data_o,       64'd0);
    check({pfx, "_core_key_o"},   bus.core_key_o,        64'd0);
    check({pfx, "_core_mode_o"},  64'(bus.core_mode_o),  64'd0);
  endtask

  // Leaves reset and confirms ready_o only rises after the first clock edge.
  task automatic release_reset(input string pfx);
    tick();
    tick();
    reset_i = 1'b0;
    #1;
    check({pfx, "_ready_before_edge"}, 64'(bus.ready_o), 64'd0);
    @(posedge clk_i);
    #1;
    check({pfx, "_ready_after_edge"}, 64'(bus.ready_o), 64'd1);
  endtask

  task automatic send(input logic st, input logic [1:0] mode, input logic dec,
                      input logic [63:0] key, input logic [63:0] iv, input logic [63:0] data,
                      input string tag, input logic [63:0] exp);
    int cyc = 0;
    tick();
    while (!bus.ready_o && cyc < 100) begin
      tick();
      cyc++;
    end
    if (!bus.ready_o) begin
      check({tag, "_ready_timeout"}, 64'(bus.ready_o), 64'd1);
      return;
    end
    bus.start_i = st;
    bus.mode_i  = mode;
    bus.dec_i   = dec;
    bus.key_i   = key;
    bus.iv_i    = iv;
    bus.data_i  = data;
    bus.valid_i = 1'b1;
    sb.push_back('{tag, exp});
    pulses_exp++;
    tick();
    bus.valid_i = 1'b0;
    bus.start_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    while ((sb.size() != 0 || bus.valid_o) && cyc < 200) begin
      @(posedge clk_i);
      cyc++;
    end
    #2;
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    check({tag, "_core_pulses"}, 64'(n_core), 64'(pulses_exp));
  endtask

  // Output monitor: pops the scoreboard on each completed output handshake.
  always @(negedge clk_i) begin
    if (bus.core_valid_o) n_core++;
    if (!reset_i && bus.valid_o && bus.ready_i) begin
      if (sb.size() == 0) begin
        check("spurious_valid_o", 64'(bus.valid_o), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.tag, bus.data_o, mon_e.data);
      end
    end
  end

  // Stub core: answers each request LAT cycles later unless reset intervenes.
  initial begin
    logic [63:0] cin, ckey;
    logic        cdec, abort;
    bus.core_valid_i = 1'b0;
    bus.core_data_i  = '0;
    forever begin
      @(negedge clk_i);
      if (!reset_i && bus.core_valid_o) begin
        cin   = bus.core_data_o;
        ckey  = bus.core_key_o;
        cdec  = bus.core_mode_o;
        abort = 1'b0;
        core_in_log.push_back(cin);
        for (int i = 0; i < LAT; i++) begin
          @(posedge clk_i);
          if (reset_i) abort = 1'b1;
        end
        #2;
        if (reset_i) abort = 1'b1;
        if (!abort) begin
          bus.core_data_i  = core_model(cin, ckey, cdec);
          bus.core_valid_i = 1'b1;
          @(posedge clk_i);
          #2;
          bus.core_valid_i = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          log_idx;
    logic [63:0] c1, c2;
    bus.start_i = 1'b0;
    bus.mode_i  = 2'b00;
    bus.dec_i   = 1'b0;
    bus.key_i   = '0;
    bus.iv_i    = '0;
    bus.data_i  = '0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    #1;
    check_zero_outs("rst");
    release_reset("rst");

    send(1'b1, MODE_ECB, 1'b0, DES_K, '0, DES_P, "ecb_des_enc", DES_C);
    send(1'b1, MODE_ECB, 1'b1, DES_K, '0, DES_C, "ecb_des_dec", DES_P);
    send(1'b1, MODE_RSVD, 1'b0, K_STUB, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_2222_3333_4444,
         "rsvd_as_ecb", 64'h1E1E_2D2D_3C3C_4B4B);
    drain("ecb");

    c1 = 64'h0E2C4A6886A4C2E0;
    c2 = 64'h0123456789ABCDEF;
    send(1'b1, MODE_CBC, 1'b0, K_STUB, '0, 64'h0123456789ABCDEF, "cbc_enc_b0", c1);
    drain("cbc_enc_b0");
    // start_i without valid_i must not restart the chain.
    tick();
    bus.start_i = 1'b1;
    bus.iv_i    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.start_i = 1'b0;
    send(1'b0, MODE_CBC, 1'b0, K_STUB, '0, 64'h0, "cbc_enc_b1", c2);
    send(1'b1, MODE_CBC, 1'b1, K_STUB, '0, c1, "cbc_dec_b0", 64'h0123456789ABCDEF);
    send(1'b0, MODE_CBC, 1'b1, K_STUB, '0, c2, "cbc_dec_b1", 64'h0);
    drain("cbc");

    log_idx = core_in_log.size();
    send(1'b1, MODE_CTR, 1'b1, K_STUB, 64'hAAAAAAAAFFFFFFFF, 64'h0, "ctr_b0",
         64'hA5A5A5A5F0F0F0F0);
    send(1'b0, MODE_CTR, 1'b0, K_STUB, '0, 64'h0, "ctr_b1", 64'hA5A5A5A50F0F0F0F);
    drain("ctr");
    if (core_in_log.size() >= log_idx + 2) begin
      check("ctr_core_in0", core_in_log[log_idx],     64'hAAAAAAAAFFFFFFFF);
      check("ctr_core_in1", core_in_log[log_idx + 1], 64'hAAAAAAAA00000000);
    end else begin
      check("ctr_core_in_count", 64'(core_in_log.size()), 64'(log_idx + 2));
    end

    // Backpressure: result must sit unchanged in HOLD while ready_i is low.
    bus.ready_i = 1'b0;
    send(1'b1, MODE_ECB, 1'b0, K_STUB, '0, 64'h5555_6666_7777_8888, "bp_out",
         64'h5A5A_6969_7878_8787);
    for (int i = 0; i < 50 && !bus.valid_o; i++) @(negedge clk_i);
    check("bp_valid_seen", 64'(bus.valid_o), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("bp_valid_held", 64'(bus.valid_o), 64'd1);
      check("bp_data_held",  bus.data_o, 64'h5A5A_6969_7878_8787);
      check("bp_ready_low",  64'(bus.ready_o), 64'd0);
    end
    check("bp_core_pulses", 64'(n_core), 64'(pulses_exp));
    tick();
    bus.ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("bp_ready_back", 64'(bus.ready_o), 64'd1);
    check("bp_valid_drop", 64'(bus.valid_o), 64'd0);
    drain("bp");

    // Reset during the core latency discards the in-flight block.
    send(1'b1, MODE_CBC, 1'b0, K_STUB, 64'h1234, 64'h9999, "rst_mid_lost", 64'h0);
    tick();
    reset_i = 1'b1;
    sb.delete();
    #1;
    check_zero_outs("rst_mid");
    release_reset("rst_mid");
    repeat (8) tick();
    check("rst_mid_no_valid", 64'(bus.valid_o), 64'd0);
    send(1'b0, MODE_CTR, 1'b1, K_STUB, 64'hFFFF, 64'hDEAD_BEEF_0BAD_F00D, "post_rst_ecb_k0",
         64'hDEAD_BEEF_0BAD_F00D);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
